mis_stim_gen: RTL and testbench
===============================

// Module: mis_stim_gen
// PURPOSE
//   Upstream stimulus source for the NOR MIS delay-chain test structure.
//   Generates two registered, glitch-free pulse trains myin_A and myin_B with a
//   programmable signed skew, pulse width, gap and pulse count.
//   Exercises multiple-input-switching at the MIS NOR stage after the
//   equal-length A/B chains.
// PARAMETERS
//   CNT_W    8   width of cfg_width, cfg_gap, cfg_count; cfg_skew is CNT_W-bit two's complement
// PORTS
//   clk        in   1      single clock, all logic on rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      launch request, sampled only in IDLE
//   cfg_skew   in   CNT_W  signed edge offset, B minus A, in cycles (>0: B lags)
//   cfg_width  in   CNT_W  high time of each pulse in cycles; 0 treated as 1
//   cfg_gap    in   CNT_W  low time after the lagging output falls; 0 allowed
//   cfg_count  in   CNT_W  number of pulses; 0 = none
//   myin_A     out  1      stimulus to chain A (direct flop output)
//   myin_B     out  1      stimulus to chain B (direct flop output)
//   busy       out  1      high in RUN
//   done       out  1      one-cycle pulse when the sequence completes
//   pulse_cnt  out  CNT_W  pulses fully emitted in the current/last run
// BEHAVIOUR
//   Reset: state=IDLE; myin_A=myin_B=busy=done=0; pulse_cnt=0.
//   Reset mid-run: all outputs forced to these values at the next edge.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     - start=1 latches cfg_* and clears pulse_cnt.
//     - Goes to RUN, or to DONE if cfg_count=0.
//     - start in RUN/DONE is ignored; cfg changes after the latch are ignored.
//   RUN:
//     - Period counter t (CNT_W+2 bits) runs 0..P-1.
//     - P = |skew| + w + gap, where w = max(cfg_width, 1).
//     - ta = (skew<0) ? -skew : 0; tb = (skew>0) ? skew : 0.
//     - |skew| is computed unsigned, so -2^(CNT_W-1) gives 2^(CNT_W-1).
//   Output timing:
//     - Cycle n=0 is the cycle after the edge that samples start.
//     - myin_A is high in cycles where ta <= t < ta+w.
//     - myin_B is high in cycles where tb <= t < tb+w.
//     - Outputs come from flops loaded with the decode of next-t, so there is
//       no combinational glitch.
//   skew=0: A and B switch on the same edge (simultaneous MIS case).
//   End of period (t=P-1):
//     - pulse_cnt increments and t wraps to 0.
//     - If pulse_cnt+1 == cfg_count, go to DONE instead.
//   gap=0: back-to-back periods; the leading output may rise on the edge right
//     after the lagging output falls.
//   DONE: done=1 and busy=0 for one cycle; both outputs low; then IDLE.
//     - A start in the cycle after DONE is accepted normally.
//   Both outputs are guaranteed low in IDLE and DONE.
// CONFIGURATION
//   STIM_SWEEP_EN defined:
//     - After each completed period the working skew increments by 1, which
//       sweeps the MIS separation.
//     - Increments saturate at +(2^(CNT_W-1)-1).
//     - P is recomputed from the new skew for the next period.
//   STIM_SWEEP_EN undefined: skew is constant for the whole run; no sweep
//     logic is synthesised.
// TESTING
//   1. rst held 3 cycles mid-RUN -> myin_A=myin_B=busy=0 next edge; pulse_cnt=0; no done.
//   2. skew=0, w=4, gap=2, count=3 -> A and B identical, high n=0..3, 6..9, 12..15;
//      done at n=18; pulse_cnt=3.
//   3. skew=+3, w=2, gap=1, count=1 -> A high n=0..1, B high n=3..4; done at n=6.
//   4. skew=-2, w=0, gap=0, count=2 -> B high n=0 and n=3; A high n=2 and n=5;
//      done at n=6.
//   5. count=0 -> no output activity; done one cycle after start; start during
//      RUN ignored (pulse_cnt unaffected).
//   6. STIM_SWEEP_EN, skew=-1, w=2, gap=1, count=3 -> separations -1, 0, +1 on
//      successive pulses; without the macro all three are -1.

Source files
------------

// File: rtl/mis_stim_gen.sv
// Two-output pulse-train generator for MIS delay-chain tests. Optional skew sweep
// between periods is enabled by defining STIM_SWEEP_EN.
module mis_stim_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_skew,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             myin_A,
  output logic             myin_B,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam int TW = CNT_W + 2;
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]    ZERO_T = {TW{1'b0}};
  localparam logic [TW-1:0]    ONE_T  = {{(TW-1){1'b0}}, 1'b1};
`ifdef STIM_SWEEP_EN
  localparam logic [CNT_W-1:0] SKEW_MAX = {1'b0, {(CNT_W-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [CNT_W-1:0] skew_q, skew_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d;
  logic [TW-1:0]    period_m1_s, ta_s, tb_s, w_s;

  // Unsigned magnitude of a two's complement skew; the most negative value maps to 2^(CNT_W-1).
  function automatic logic [TW-1:0] mag(input logic [CNT_W-1:0] s);
    logic [CNT_W-1:0] m;
    if (s[CNT_W-1]) begin
      m = ~s + ONE_C;
    end else begin
      m = s;
    end
    return {2'b00, m};
  endfunction

  function automatic logic [TW-1:0] weff(input logic [CNT_W-1:0] w);
    logic [TW-1:0] r;
    if (w == ZERO_C) begin
      r = ONE_T;
    end else begin
      r = {2'b00, w};
    end
    return r;
  endfunction

  // Next-state, period counter and output decode of the next cycle.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    skew_d      = skew_q;
    width_d     = width_q;
    gap_d       = gap_q;
    count_d     = count_q;
    pulse_cnt_d = pulse_cnt_q;
    period_m1_s = mag(skew_q) + weff(width_q) + {2'b00, gap_q} - ONE_T;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          skew_d      = cfg_skew;
          width_d     = cfg_width;
          gap_d       = cfg_gap;
          count_d     = cfg_count;
          pulse_cnt_d = ZERO_C;
          t_d         = ZERO_T;
          if (cfg_count == ZERO_C) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (t_q == period_m1_s) begin
          t_d         = ZERO_T;
          pulse_cnt_d = pulse_cnt_q + ONE_C;
`ifdef STIM_SWEEP_EN
          if (skew_q != SKEW_MAX) begin
            skew_d = skew_q + ONE_C;
          end else begin
            skew_d = skew_q;
          end
`endif
          if (pulse_cnt_q + ONE_C == count_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          t_d = t_q + ONE_T;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Decode is taken from the next-cycle values so the outputs are pure flops.
    w_s = weff(width_d);
    if (skew_d[CNT_W-1]) begin
      ta_s = mag(skew_d);
      tb_s = ZERO_T;
    end else if (skew_d != ZERO_C) begin
      ta_s = ZERO_T;
      tb_s = mag(skew_d);
    end else begin
      ta_s = ZERO_T;
      tb_s = ZERO_T;
    end
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    a_d    = busy_d && (t_d >= ta_s) && (t_d < ta_s + w_s);
    b_d    = busy_d && (t_d >= tb_s) && (t_d < tb_s + w_s);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      t_q         <= ZERO_T;
      skew_q      <= ZERO_C;
      width_q     <= ZERO_C;
      gap_q       <= ZERO_C;
      count_q     <= ZERO_C;
      pulse_cnt_q <= ZERO_C;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      skew_q      <= skew_d;
      width_q     <= width_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      pulse_cnt_q <= pulse_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign myin_A    = a_q;
  assign myin_B    = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_mis_stim_gen.sv
// Self-checking bench for mis_stim_gen: directed and random runs against a
// cycle-list reference model built from the pulse-train rules.
module tb_mis_stim_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_skew, cfg_width, cfg_gap, cfg_count;
  logic       myin_A, myin_B, busy, done;
  logic [7:0] pulse_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mis_stim_gen #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_skew(cfg_skew), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
    .myin_A(myin_A), .myin_B(myin_B), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int a, input int b, input int bz,
                         input int dn, input int pc);
    chk({tag, ".A"},    {31'd0, myin_A}, a);
    chk({tag, ".B"},    {31'd0, myin_B}, b);
    chk({tag, ".busy"}, {31'd0, busy},   bz);
    chk({tag, ".done"}, {31'd0, done},   dn);
    chk({tag, ".pcnt"}, {24'd0, pulse_cnt}, pc);
  endtask

  // Must be called at a negedge; checks n idle cycles.
  task automatic idle_check(input int n, input int pc);
    for (int i = 0; i < n; i++) begin
      chk_all("idle", 0, 0, 0, 0, pc);
      @(negedge clk);
    end
  endtask

  // Called at a negedge. Launches one run and checks every cycle through DONE,
  // ending at the negedge of the cycle after DONE.
  task automatic run(input string tag, input int skew, input int width, input int gap,
                     input int count, input bit noise);
    int ea[$], eb[$], ebz[$], edn[$], epc[$];
    int s, w, mg, ta, tb, p;
    logic [31:0] tmp;
    s = skew;
    w = (width == 0) ? 1 : width;
    for (int k = 0; k < count; k++) begin
      mg = (s < 0) ? -s : s;
      ta = (s < 0) ? -s : 0;
      tb = (s > 0) ? s : 0;
      p  = mg + w + gap;
      for (int t = 0; t < p; t++) begin
        ea.push_back((t >= ta && t < ta + w) ? 1 : 0);
        eb.push_back((t >= tb && t < tb + w) ? 1 : 0);
        ebz.push_back(1); edn.push_back(0); epc.push_back(k);
      end
`ifdef STIM_SWEEP_EN
      if (s < 127) s++;
`endif
    end
    ea.push_back(0); eb.push_back(0); ebz.push_back(0); edn.push_back(1); epc.push_back(count);

    tmp = skew;
    cfg_skew = tmp[7:0]; cfg_width = width[7:0]; cfg_gap = gap[7:0]; cfg_count = count[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (noise) begin
      cfg_skew = $urandom; cfg_width = $urandom; cfg_gap = $urandom; cfg_count = $urandom;
    end
    for (int i = 0; i < ea.size(); i++) begin
      chk_all(tag, ea[i], eb[i], ebz[i], edn[i], epc[i]);
      start = (noise && ebz[i] == 1 && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int sk, wd, gp, ct;
    rst = 1'b1; start = 1'b0;
    cfg_skew = 8'd0; cfg_width = 8'd0; cfg_gap = 8'd0; cfg_count = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    idle_check(2, 0);

    // Reset held for three cycles in the middle of a run.
    cfg_skew = 8'd0; cfg_width = 8'd4; cfg_gap = 8'd2; cfg_count = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrun.busy", {31'd0, busy}, 1);
    chk("midrun.pcnt", {24'd0, pulse_cnt}, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all("rst_mid", 0, 0, 0, 0, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    idle_check(3, 0);

    run("simul",  0, 4, 2, 3, 1'b0);
    idle_check(1, 3);
    run("lagB",   3, 2, 1, 1, 1'b0);
    run("lagA",  -2, 0, 0, 2, 1'b0);
    idle_check(1, 2);
    run("cnt0",   5, 3, 1, 0, 1'b0);
    idle_check(1, 0);
    run("ignore", 1, 2, 1, 2, 1'b1);
    idle_check(1, 2);
    run("sweep", -1, 2, 1, 3, 1'b0);
    idle_check(1, 3);
    run("negmax", -128, 255, 255, 1, 1'b0);
    run("posmax",  127, 3, 0, 2, 1'b0);
    idle_check(1, 2);

    for (int r = 0; r < 25; r++) begin
      sk = $urandom_range(0, 40) - 20;
      if ($urandom_range(0, 9) == 0) sk = ($urandom_range(0, 1) == 1) ? 127 : -128;
      wd = $urandom_range(0, 12);
      gp = $urandom_range(0, 10);
      ct = $urandom_range(0, 5);
      run("rand", sk, wd, gp, ct, 1'b1);
      if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 3), ct);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
